// File: rtl/brownout_pkg.sv
// Shared types and threshold constants for the AVDD brownout / undervoltage monitor.
package brownout_pkg;

    localparam int unsigned MV_W          = 12;
    localparam int unsigned THR_W         = 13;
    localparam int unsigned TRIP_W        = 3;
    localparam int unsigned DIV_W         = 8;
    localparam int unsigned TICK_W        = 8;
    localparam int unsigned FILT_W        = 4;

    localparam int unsigned OTRIP_BASE_MV = 2000;
    localparam int unsigned OTRIP_STEP_MV = 100;
    localparam int unsigned VTRIP_BASE_MV = 1600;
    localparam int unsigned VTRIP_STEP_MV = 50;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BROWN = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Trip code to millivolt threshold; 13 bits so base + step*7 + hysteresis never wraps.
    function automatic logic [THR_W-1:0] trip_to_mv(
        input logic [TRIP_W-1:0] code,
        input int unsigned       base_mv,
        input int unsigned       step_mv
    );
        return THR_W'(base_mv) + (THR_W'(step_mv) * THR_W'(code));
    endfunction

endpackage

// File: rtl/brownout_filt.sv
// Debounce: output toggles on the FILT_LEN-th consecutive sample that differs from it.
module brownout_filt
    import brownout_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic filt
);

    localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_LEN - 1);

    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              filt_q, filt_d;

    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (raw == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_d = ~filt_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + FILT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/brownout_det.sv
// AVDD brownout / undervoltage monitor with debounced trip and one-shot recovery hold.
// Debug outputs and force_short_oneshot are only live when BROWNOUT_DEBUG_EN is defined.
module brownout_det
    import brownout_pkg::*;
#(
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned HYST_MV     = 50,
    parameter int unsigned LONG_TICKS  = 64,
    parameter int unsigned SHORT_TICKS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MV_W-1:0]   avdd_mv,
    input  logic [TRIP_W-1:0] otrip,
    input  logic [TRIP_W-1:0] vtrip,
    input  logic              ena,
    input  logic              force_short_oneshot,
    output logic              out,
    output logic              vunder,
    output logic              osc_ck_256,
    output logic              brout_filt,
    output logic              timed_out
);

    logic              clr;
    logic [MV_W-1:0]   sample_q, sample_d;
    logic              sample_vld_q, sample_vld_d;
    logic              raw_q, raw_d;
    logic              vunder_q, vunder_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TICK_W-1:0] oneshot_len;
    logic              out_q, out_d;
    logic              timed_out_q, timed_out_d;
    logic              tick;
    logic              filt;
    logic              brown_req;
    logic [THR_W-1:0]  thr_b, thr_b_rel, thr_u, sample_ext;
    state_e            state_q, state_d;

    assign clr        = rst | ~ena;
    assign thr_b      = trip_to_mv(otrip, OTRIP_BASE_MV, OTRIP_STEP_MV);
    assign thr_b_rel  = thr_b + THR_W'(HYST_MV);
    assign thr_u      = trip_to_mv(vtrip, VTRIP_BASE_MV, VTRIP_STEP_MV);
    assign sample_ext = THR_W'(sample_q);
    assign tick       = (div_q == '1);
    assign brown_req  = filt | vunder_q;

`ifdef BROWNOUT_DEBUG_EN
    assign oneshot_len = force_short_oneshot ? TICK_W'(SHORT_TICKS) : TICK_W'(LONG_TICKS);
`else
    assign oneshot_len = TICK_W'(LONG_TICKS);
`endif

    // Sample pipeline, hysteretic comparator and tick divider.
    // The valid flag keeps the cleared sample register from looking like a 0 mV dip.
    always_comb begin
        sample_d     = avdd_mv;
        sample_vld_d = 1'b1;
        raw_d        = raw_q;
        vunder_d     = vunder_q;
        div_d        = div_q + DIV_W'(1);
        if (sample_vld_q) begin
            if (sample_ext < thr_b) begin
                raw_d = 1'b1;
            end else if (sample_ext >= thr_b_rel) begin
                raw_d = 1'b0;
            end
            vunder_d = (sample_ext < thr_u);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            raw_q        <= 1'b0;
            vunder_q     <= 1'b0;
            div_q        <= '0;
        end else begin
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            raw_q        <= raw_d;
            vunder_q     <= vunder_d;
            div_q        <= div_d;
        end
    end

    brownout_filt #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk  (clk),
        .clr  (clr),
        .raw  (raw_q),
        .filt (filt)
    );

    // State register, with the one-shot tick count and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            out_q       <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            out_q       <= out_d;
            timed_out_q <= timed_out_d;
        end
    end

    // Next state; a reassertion in HOLD takes priority over expiry.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (brown_req) begin
                    state_d = BROWN;
                end
            end
            BROWN: begin
                if (!brown_req) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (brown_req) begin
                    state_d = BROWN;
                end else if (tick_cnt_q >= oneshot_len) begin
                    state_d = IDLE;
                end else begin
                    tick_cnt_d = tick_cnt_q;
                    if (tick && (tick_cnt_q != '1)) begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs follow the state being entered, so out lags brout_filt by one cycle.
    always_comb begin
        out_d       = (state_d != IDLE);
        timed_out_d = (state_q == HOLD) && (state_d == IDLE);
    end

    assign out    = out_q;
    assign vunder = vunder_q;

`ifdef BROWNOUT_DEBUG_EN
    assign osc_ck_256 = div_q[DIV_W-1];
    assign brout_filt = filt;
    assign timed_out  = timed_out_q;
`else
    logic unused_dbg;
    assign unused_dbg = ^{force_short_oneshot, timed_out_q};
    assign osc_ck_256 = 1'b0;
    assign brout_filt = 1'b0;
    assign timed_out  = 1'b0;
`endif

endmodule

// File: tb/tb_brownout_det.sv
// Self-checking bench for brownout_det: vector table, directed sequences and a randomized run
// against a behavioural model. Debug-output expectations follow BROWNOUT_DEBUG_EN.
module tb_brownout_det;

    localparam int FILT_LEN    = 4;
    localparam int HYST_MV     = 50;
    localparam int LONG_TICKS  = 64;
    localparam int SHORT_TICKS = 2;
`ifdef BROWNOUT_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_BROWN = 1;
    localparam int M_HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] avdd;
    logic [2:0]  otrip, vtrip;
    logic        ena, fso;
    logic        out, vunder, osc, bfilt, tout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    brownout_det dut (
        .clk                 (clk),
        .rst                 (rst),
        .avdd_mv             (avdd),
        .otrip               (otrip),
        .vtrip               (vtrip),
        .ena                 (ena),
        .force_short_oneshot (fso),
        .out                 (out),
        .vunder              (vunder),
        .osc_ck_256          (osc),
        .brout_filt          (bfilt),
        .timed_out           (tout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model: thresholds from arithmetic, debounce as a history of differing samples,
    // one-shot as a count of divide-by-256 ticks seen since entering the hold.
    int  m_sample, m_mode, m_ticks, m_edges, m_thr_b, m_thr_u, m_len;
    bit  m_have, m_raw, m_vund, m_filt, m_tout, m_tick, m_brown;
    bit  m_hist[$];
    bit  mchk = 1'b0;
    logic [4:0] m_act, m_exp;

    always @(posedge clk) begin
        if (rst || !ena) begin
            m_sample = 0;
            m_have   = 1'b0;
            m_raw    = 1'b0;
            m_vund   = 1'b0;
            m_filt   = 1'b0;
            m_hist.delete();
            m_mode   = M_IDLE;
            m_ticks  = 0;
            m_edges  = 0;
            m_tout   = 1'b0;
        end else begin
            m_thr_b = 2000 + 100 * int'(otrip);
            m_thr_u = 1600 + 50 * int'(vtrip);
            m_len   = (DBG && fso) ? SHORT_TICKS : LONG_TICKS;
            m_tick  = ((m_edges % 256) == 255);
            m_brown = m_filt || m_vund;
            m_tout  = 1'b0;
            case (m_mode)
                M_IDLE:  if (m_brown) m_mode = M_BROWN;
                M_BROWN: if (!m_brown) begin m_mode = M_HOLD; m_ticks = 0; end
                default: begin
                    if (m_brown) begin
                        m_mode = M_BROWN;
                        m_ticks = 0;
                    end else if (m_ticks >= m_len) begin
                        m_mode = M_IDLE;
                        m_tout = 1'b1;
                    end else if (m_tick && m_ticks < 255) begin
                        m_ticks++;
                    end
                end
            endcase
            if (m_raw == m_filt) begin
                m_hist.delete();
            end else begin
                m_hist.push_back(m_raw);
                if (m_hist.size() == FILT_LEN) begin
                    m_filt = !m_filt;
                    m_hist.delete();
                end
            end
            if (m_have) begin
                if (m_sample < m_thr_b) m_raw = 1'b1;
                else if (m_sample >= m_thr_b + HYST_MV) m_raw = 1'b0;
                m_vund = (m_sample < m_thr_u);
            end
            m_sample = int'(avdd);
            m_have   = 1'b1;
            m_edges++;
        end
    end

    always @(negedge clk) begin
        if (mchk) begin
            m_act = {out, vunder, osc, bfilt, tout};
            m_exp = {m_mode != M_IDLE, m_vund,
                     DBG && ((m_edges % 256) >= 128), DBG && m_filt, DBG && m_tout};
            check("model_outs", 32'(m_act), 32'(m_exp));
        end
    end

    typedef struct {
        logic [11:0] avdd;
        logic [2:0]  ot;
        logic [2:0]  vt;
        bit          exp_vund;
        bit          exp_out;
        bit          exp_bf;
    } vec_t;

    vec_t vecs[12];

    int  n, first_tog, togs, tout_cnt;
    bit  seen, prev_osc;

    initial begin
        rst = 1'b1; ena = 1'b0; fso = 1'b0; avdd = 12'd3300; otrip = 3'd7; vtrip = 3'd7;

        vecs[0]  = '{12'd3300, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{12'd2200, 3'd7, 3'd7, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{12'd2699, 3'd7, 3'd7, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{12'd2700, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{12'd1999, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{12'd2000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{12'd1599, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{12'd1600, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{12'd1949, 3'd3, 3'd7, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{12'd1950, 3'd3, 3'd7, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{12'd2400, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{12'd2299, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1};

        step(2);
        check("reset_outs", 32'({out, vunder, osc, bfilt, tout}), 32'd0);

        // Disabled block stays quiet even with a low supply.
        rst = 1'b0; ena = 1'b0; avdd = 12'd2200;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if ({out, vunder, osc, bfilt, tout} != 5'd0) seen = 1'b1;
        end
        check("ena0_quiet", 32'(seen), 32'd0);

        // Healthy supply: no request, divider runs.
        ena = 1'b1; avdd = 12'd3300;
        seen = 1'b0; prev_osc = osc; first_tog = -1; togs = 0;
        for (int i = 1; i <= 600; i++) begin
            step(1);
            if (out) seen = 1'b1;
            if (osc !== prev_osc) begin
                togs++;
                if (first_tog < 0) first_tog = i;
            end
            prev_osc = osc;
        end
        check("healthy_out", 32'(seen), 32'd0);
        check("osc_toggles", 32'(togs), DBG ? 32'd4 : 32'd0);
        if (DBG) check("osc_first_toggle", 32'(first_tog), 32'd128);

        // Brownout: filter after 2+FILT_LEN cycles, out one cycle later.
        avdd = 12'd2200;
        n = 0; first_tog = -1;
        while (out !== 1'b1 && n < 50) begin
            step(1);
            n++;
            if (bfilt === 1'b1 && first_tog < 0) first_tog = n;
        end
        check("brown_out_latency", 32'(n), 32'd7);
        if (DBG) check("brown_filt_latency", 32'(first_tog), 32'd6);
        check("brown_vunder", 32'(vunder), 32'd0);

        // Recovery with the long one-shot.
        avdd = 12'd3300; fso = 1'b0;
        n = 0;
        while (out !== 1'b0 && n < 20000) begin step(1); n++; end
        check_range("long_hold_len", n, 16137, 16392);
        check("long_timed_out_pulse", 32'(tout), DBG ? 32'd1 : 32'd0);
        step(1);
        check("long_timed_out_end", 32'(tout), 32'd0);

        // Short one-shot (ignored unless debug build).
        fso = 1'b1; avdd = 12'd2200;
        step(10);
        check("short_brown_out", 32'(out), 32'd1);
        avdd = 12'd3300;
        n = 0;
        while (out !== 1'b0 && n < 20000) begin step(1); n++; end
        if (DBG) check_range("short_hold_len", n, 265, 520);
        else     check_range("short_ignored_len", n, 16137, 16392);
        check("short_timed_out_pulse", 32'(tout), DBG ? 32'd1 : 32'd0);

        // Dip during HOLD returns to BROWN without a timeout pulse; then reset mid-HOLD.
        avdd = 12'd2200; step(10);
        avdd = 12'd3300; step(20);
        check("hold_out", 32'(out), 32'd1);
        avdd = 12'd2200;
        seen = 1'b0; tout_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (out !== 1'b1) seen = 1'b1;
            if (tout !== 1'b0) tout_cnt++;
        end
        check("dip_out_held", 32'(seen), 32'd0);
        check("dip_no_timeout", 32'(tout_cnt), 32'd0);
        avdd = 12'd3300; step(20);
        check("rehold_out", 32'(out), 32'd1);
        rst = 1'b1; step(1);
        check("rst_mid_hold_out", 32'(out), 32'd0);
        rst = 1'b0; fso = 1'b0; step(10);

        // Undervoltage path and hysteresis.
        avdd = 12'd1900;
        step(1);
        check("vunder_lat1", 32'(vunder), 32'd0);
        step(1);
        check("vunder_lat2", 32'(vunder), 32'd1);
        step(1);
        check("vunder_out", 32'(out), 32'd1);
        avdd = 12'd2660; step(20);
        check("hyst_2660_out", 32'(out), 32'd1);
        check("hyst_2660_vunder", 32'(vunder), 32'd0);
        avdd = 12'd2720; step(20);
        check("hyst_2720_out", 32'(out), 32'd1);
        if (DBG) check("hyst_2720_filt", 32'(bfilt), 32'd1);
        avdd = 12'd2750; step(8);
        check("hyst_release_out", 32'(out), 32'd1);
        if (DBG) check("hyst_release_filt", 32'(bfilt), 32'd0);

        // Static vector table, each from a fresh reset.
        for (int i = 0; i < 12; i++) begin
            rst = 1'b1; step(1);
            rst = 1'b0; ena = 1'b1;
            avdd = vecs[i].avdd; otrip = vecs[i].ot; vtrip = vecs[i].vt;
            step(12);
            check($sformatf("vec%0d_vunder", i), 32'(vunder), 32'(vecs[i].exp_vund));
            check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
            if (DBG) check($sformatf("vec%0d_filt", i), 32'(bfilt), 32'(vecs[i].exp_bf));
        end

        // Randomized run against the model.
        fso = 1'b0;
        mchk = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)   avdd  = 12'($urandom_range(1500, 3300));
            if ($urandom_range(0, 199) == 0) otrip = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) vtrip = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) fso   = ~fso;
            ena = ($urandom_range(0, 499) != 0);
            rst = ($urandom_range(0, 699) == 0);
            step(1);
        end
        @(negedge clk);
        mchk = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/brownout_det.md
Name: brownout_det

Overview:
- Clocked digital model of the AVDD brownout / undervoltage monitor.
- Compares a quantized AVDD sample against two programmable thresholds: brownout (otrip) and undervoltage (vtrip).
- Debounces the brownout comparison and holds `out` asserted for a one-shot recovery timeout after AVDD returns.
- Sits in the always-on power-management domain and feeds the chip-level reset generator.

Parameters:
- FILT_LEN, 4: consecutive samples needed to change brout_filt (range 1..15).
- HYST_MV, 50: brownout release hysteresis in mV.
- LONG_TICKS, 64: one-shot length in divide-by-256 ticks (normal mode).
- SHORT_TICKS, 2: one-shot length in ticks when force_short_oneshot=1.

Ports:
- clk  in  1  oscillator/system clock, all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- avdd_mv  in  12  AVDD sample, unsigned millivolts.
- otrip  in  3  brownout threshold select.
- vtrip  in  3  undervoltage threshold select.
- ena  in  1  block enable.
- force_short_oneshot  in  1  use SHORT_TICKS (fast simulation).
- out  out  1  brownout reset request.
- vunder  out  1  undervoltage flag.
- osc_ck_256  out  1  clk divided by 256.
- brout_filt  out  1  debounced brownout comparator.
- timed_out  out  1  one-cycle pulse at one-shot expiry.

Behaviour:
- Reset: all outputs 0; divider, filter and one-shot counters cleared; state IDLE.
- ena=0: same as reset, held every cycle; outputs 0.
- Thresholds (12-bit mV):
  - brownout thr_b = 2000 + 100*otrip (otrip=111 gives 2700).
  - undervoltage thr_u = 1600 + 50*vtrip (vtrip=111 gives 1950).
- avdd_mv is registered once (cycle 1).
- Raw brownout (cycle 2):
  - Sets when sample < thr_b.
  - Clears when sample >= thr_b + HYST_MV.
  - Otherwise holds its previous value.
- vunder = registered (sample < thr_u); 2-cycle latency, no filtering.
- Filter:
  - 4-bit run counter; resets to 0 whenever raw equals brout_filt.
  - brout_filt toggles when the counter reaches FILT_LEN-1 while raw differs from brout_filt.
  - Net effect: toggles on the FILT_LEN-th consecutive differing sample.
- Divider: 8-bit free-running counter while ena=1.
  - osc_ck_256 = bit 7.
  - tick = counter==255.
- State machine:
  - IDLE: out=0. Goes to BROWN when brout_filt=1 or vunder=1.
  - BROWN: out=1. Goes to HOLD when brout_filt=0 and vunder=0; tick counter cleared.
  - HOLD: out=1; counts ticks.
    - When the count reaches the selected length (LONG_TICKS, or SHORT_TICKS if force_short_oneshot=1): go to IDLE; timed_out=1 for exactly that cycle.
    - brout_filt or vunder reasserting in HOLD: return to BROWN, counter cleared; timed_out stays 0.
- out is registered from the state (asserted in BROWN and HOLD).
- force_short_oneshot change during HOLD: the new length is used immediately; if the count already >= the new length, expire on the next cycle.
- Arithmetic widths:
  - Threshold sums computed in 13 bits, no wrap.
  - The tick counter saturates at 2^8-1; LONG_TICKS <= 255.
- rst mid-HOLD: back to IDLE, out=0 next cycle.

Optional Feature:
- Macro BROWNOUT_DEBUG_EN.
- Defined: osc_ck_256, brout_filt and timed_out are driven as specified; force_short_oneshot is honoured.
- Undefined: these three outputs are tied to 0; force_short_oneshot is ignored (always LONG_TICKS). out and vunder behaviour is unchanged.

Decomposition:
- Package brownout_pkg holds:
  - state enum {IDLE, BROWN, HOLD};
  - threshold base and step constants (2000/100, 1600/50 mV);
  - a function mapping trip codes to mV thresholds.
- One natural sub-module, brownout_filt: the FILT_LEN debounce counter (raw in, filtered out).

Test Plan:
- ena=0, avdd_mv=2200, otrip=vtrip=111 -> out=vunder=brout_filt=0 for 1000 cycles; osc_ck_256 static 0.
- ena=1, avdd_mv=3300 -> out stays 0; osc_ck_256 toggles every 128 cycles.
- ena=1, avdd 3300 -> 2200 -> brout_filt=1 after 2+FILT_LEN cycles; out=1 one cycle later; vunder=0.
- avdd back to 3300 (>=2750), force_short_oneshot=0 -> out holds; drops after 64 ticks (16384±256 cycles); timed_out single-cycle pulse at the drop.
- force_short_oneshot=1 -> out drops after 2 ticks. A dip to 2200 during HOLD returns to BROWN, with no timed_out pulse.
- avdd_mv=1900, vtrip=111 -> vunder=1 two cycles later, out=1. avdd_mv=2660 with otrip=111 after a brownout -> still in brownout (hysteresis).
